// File: rtl/iir_pkg.sv
// Shared widths, sequencer state encoding and result saturation for the
// time-multiplexed biquad MAC scheduler.
package iir_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 40;
  localparam int FRAC   = 14;
  localparam int TAPS   = 5;
  localparam int ADDR_W = 4;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAC0,
    S_WB0,
    S_MAC1,
    S_WB1
  } state_t;

  // Input and output histories of both biquads.
  typedef struct packed {
    data_t x1;
    data_t x2;
    data_t yl1;
    data_t yl2;
    data_t yh1;
    data_t yh2;
  } hist_t;

  localparam acc_t SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam acc_t SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Drop the coefficient fraction (flooring) and clamp into the sample range.
  function automatic data_t sat(input acc_t acc);
    acc_t sh;
    sh = acc >>> FRAC;
    if (sh > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
    else if (sh < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
    else                   sat = sh[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider; tick is high for the one cycle in which
// the count sits at its terminal value.
module sample_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst || clr)        count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + 1'b1;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/iir_mac_scheduler.sv
// Shares one external MAC between the low-pass and high-pass biquads: five
// taps per channel, saturated write-back, delay lines kept here.
module iir_mac_scheduler
  import iir_pkg::*;
#(
  parameter int SAMPLE_DIV = 1000,
  parameter bit EXT_TICK   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     filter_rst,
  input  logic                     sample_strobe,
  input  logic signed [DATA_W-1:0] sample_in,
  output logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     mac_clr,
  output logic                     mac_en,
  output logic signed [COEF_W-1:0] mac_a,
  output logic signed [DATA_W-1:0] mac_b,
  input  logic signed [ACC_W-1:0]  mac_acc,
  output logic signed [DATA_W-1:0] y_low,
  output logic signed [DATA_W-1:0] y_high,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     overrun
);

  state_t     state;
  logic [2:0] tap;
  logic [2:0] tap_nxt;
  data_t      x;
  hist_t      h;
  data_t      op_nxt;
  data_t      y_sat;
  logic       div_tick;
  logic       tick;

  sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (filter_rst),
    .tick (div_tick)
  );

  assign tick    = EXT_TICK ? sample_strobe : div_tick;
  assign overrun = tick && busy && rst && !filter_rst;
  assign mac_a   = coef_data;
  assign y_sat   = sat(mac_acc);
  assign tap_nxt = tap + 3'd1;

  // Data operand for the tap issued next; taps 3/4 are the channel's own feedback.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it holding a stale value (which would infer a latch).
  always_comb begin
    op_nxt = x;
    case (tap_nxt)
      3'd1:    op_nxt = h.x1;
      3'd2:    op_nxt = h.x2;
      3'd3:    op_nxt = (state == S_MAC1) ? h.yh1 : h.yl1;
      3'd4:    op_nxt = (state == S_MAC1) ? h.yh2 : h.yl2;
      default: op_nxt = x;
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every branch
  // reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst || filter_rst) begin
      state     <= S_IDLE;
      tap       <= '0;
      x         <= '0;
      // NOTE: the delay lines are a handful of registers, not a RAM, so they
      // take the reset and the soft clear like any other state.
      h         <= '0;
      y_low     <= '0;
      y_high    <= '0;
      y_valid   <= 1'b0;
      busy      <= 1'b0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      coef_addr <= '0;
      mac_b     <= '0;
    end else begin
      y_valid <= 1'b0;
      mac_clr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            x       <= sample_in;
            busy    <= 1'b1;
            mac_clr <= 1'b1;
            state   <= S_CLR;
          end
        end
        S_CLR: begin
          tap       <= '0;
          mac_en    <= 1'b1;
          coef_addr <= ADDR_W'(0);
          mac_b     <= x;
          state     <= S_MAC0;
        end
        S_MAC0, S_MAC1: begin
          if (tap == 3'(TAPS - 1)) begin
            mac_en    <= 1'b0;
            coef_addr <= '0;
            mac_b     <= '0;
            if (state == S_MAC0) begin
              mac_clr <= 1'b1;
              state   <= S_WB0;
            end else begin
              state   <= S_WB1;
            end
          end else begin
            tap       <= tap_nxt;
            coef_addr <= coef_addr + 1'b1;
            mac_b     <= op_nxt;
          end
        end
        S_WB0: begin
          y_low     <= y_sat;
          h.yl2     <= h.yl1;
          h.yl1     <= y_sat;
          tap       <= '0;
          mac_en    <= 1'b1;
          coef_addr <= ADDR_W'(TAPS);
          mac_b     <= x;
          state     <= S_MAC1;
        end
        S_WB1: begin
          y_high  <= y_sat;
          h.yh2   <= h.yh1;
          h.yh1   <= y_sat;
          h.x2    <= h.x1;
          h.x1    <= x;
          y_valid <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_mac_scheduler.sv
// Directed bench: a behavioural coefficient ROM and MAC around the scheduler,
// a vector table of single-sample runs, and hand sequences for corner cases.
module tb_iir_mac_scheduler;
  import iir_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     filter_rst;
  logic                     sample_strobe;
  logic signed [DATA_W-1:0] sample_in;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     mac_clr;
  logic                     mac_en;
  logic signed [COEF_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic signed [ACC_W-1:0]  mac_acc;
  logic signed [DATA_W-1:0] y_low;
  logic signed [DATA_W-1:0] y_high;
  logic                     y_valid;
  logic                     busy;
  logic                     overrun;

  logic [ADDR_W-1:0]        coef_addr2;
  logic                     mac_clr2, mac_en2, y_valid2, busy2, overrun2;
  logic signed [COEF_W-1:0] mac_a2;
  logic signed [DATA_W-1:0] mac_b2, y_low2, y_high2;

  iir_mac_scheduler #(.SAMPLE_DIV(1000), .EXT_TICK(1'b1)) u_dut (
    .clk(clk), .rst(rst), .filter_rst(filter_rst), .sample_strobe(sample_strobe),
    .sample_in(sample_in), .coef_addr(coef_addr), .coef_data(coef_data),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(mac_acc), .y_low(y_low), .y_high(y_high), .y_valid(y_valid),
    .busy(busy), .overrun(overrun)
  );

  // Internal-divider instance: strobe held high must be ignored.
  iir_mac_scheduler #(.SAMPLE_DIV(20), .EXT_TICK(1'b0)) u_div (
    .clk(clk), .rst(rst), .filter_rst(1'b0), .sample_strobe(1'b1),
    .sample_in(sample_in), .coef_addr(coef_addr2), .coef_data('0),
    .mac_clr(mac_clr2), .mac_en(mac_en2), .mac_a(mac_a2), .mac_b(mac_b2),
    .mac_acc('0), .y_low(y_low2), .y_high(y_high2), .y_valid(y_valid2),
    .busy(busy2), .overrun(overrun2)
  );

  int rom [10];

  always_comb coef_data = (coef_addr < 4'd10) ? 16'(rom[coef_addr]) : 16'sd0;

  always_ff @(posedge clk) begin
    if (!rst || mac_clr) mac_acc <= '0;
    else if (mac_en)     mac_acc <= mac_acc + 40'(longint'(mac_a) * longint'(mac_b));
  end

  // Edge count since reset release, observed at the falling edge.
  int k_rel;
  int yv2_first = -1;
  int yv2_second = -1;
  bit ov2_seen = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) k_rel <= 0;
    else      k_rel <= k_rel + 1;
  end

  always @(negedge clk) begin
    if (rst && y_valid2) begin
      if (yv2_first < 0)       yv2_first = k_rel;
      else if (yv2_second < 0) yv2_second = k_rel;
    end
    if (rst && overrun2) ov2_seen = 1'b1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frst();
    filter_rst = 1'b1;
    step();
    filter_rst = 1'b0;
  endtask

  typedef struct {
    string name;
    bit    frst;
    int    rom[10];
    int    x;
    int    yl;
    int    yh;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input bit frst,
                         input int r0, input int r1, input int r2, input int r3, input int r4,
                         input int r5, input int r6, input int r7, input int r8, input int r9,
                         input int x, input int yl, input int yh);
    vec_t v;
    v.name = name; v.frst = frst;
    v.rom[0] = r0; v.rom[1] = r1; v.rom[2] = r2; v.rom[3] = r3; v.rom[4] = r4;
    v.rom[5] = r5; v.rom[6] = r6; v.rom[7] = r7; v.rom[8] = r8; v.rom[9] = r9;
    v.x = x; v.yl = yl; v.yh = yh;
    vecs.push_back(v);
  endtask

  int   en_cnt, clr_cnt, yv_cnt, yv_first, ov_cnt, ov_first, yl_fr, yh_fr;
  logic busy_fr;
  bit   ops_ok;

  // One sample sequence: strobe at cycle 0, optional second strobe at s2 and
  // filter_rst at fr; cycle c is the interval after the c-th edge.
  task automatic run_seq(input int x0, input int xb, input int s2, input int fr);
    en_cnt = 0; clr_cnt = 0; yv_cnt = 0; yv_first = -1; ov_cnt = 0; ov_first = -1;
    ops_ok = 1'b1; busy_fr = 1'bx; yl_fr = 0; yh_fr = 0;
    for (int c = 0; c < 20; c++) begin
      sample_strobe = (c == 0) || (c == s2);
      sample_in     = (c == 0) ? 16'(x0) : ((c == s2) ? 16'(xb) : 16'(c * 37));
      filter_rst    = (c == fr);
      #1;
      if (mac_en) begin
        if (en_cnt >= 10 || coef_addr != 4'(en_cnt) || mac_a != 16'(rom[en_cnt])) ops_ok = 1'b0;
        en_cnt++;
      end else if (coef_addr != '0 || mac_b != '0) begin
        ops_ok = 1'b0;
      end
      if (mac_clr) clr_cnt++;
      if (y_valid) begin yv_cnt++; if (yv_first < 0) yv_first = c; end
      if (overrun) begin ov_cnt++; if (ov_first < 0) ov_first = c; end
      if (fr >= 0 && c == fr + 1) begin
        busy_fr = busy; yl_fr = int'(y_low); yh_fr = int'(y_high);
      end
      @(posedge clk);
      #1;
    end
    sample_strobe = 1'b0;
    filter_rst    = 1'b0;
  endtask

  initial begin
    rst = 1'b0; filter_rst = 1'b0; sample_strobe = 1'b0; sample_in = '0;
    for (int i = 0; i < 10; i++) rom[i] = 0;

    //       name     frst  r0     r1     r2     r3    r4    r5      r6 r7 r8     r9    x       yl      yh
    add_vec("pass",   1, 16384, 0,     0,     0,    0,    -16384, 0, 0, 0,     0,    1000,   1000,   -1000);
    add_vec("rec0",   1, 16384, 0,     0,     8192, 0,    0,      0, 0, 0,     0,    1000,   1000,   0);
    add_vec("rec1",   0, 16384, 0,     0,     8192, 0,    0,      0, 0, 0,     0,    0,      500,    0);
    add_vec("rec2",   0, 16384, 0,     0,     8192, 0,    0,      0, 0, 0,     0,    0,      250,    0);
    add_vec("rec3",   0, 16384, 0,     0,     8192, 0,    0,      0, 0, 0,     0,    0,      125,    0);
    add_vec("satp0",  1, 32767, 32767, 0,     0,    0,    0,      0, 0, 0,     0,    32767,  32767,  0);
    add_vec("satp1",  0, 32767, 32767, 0,     0,    0,    0,      0, 0, 0,     0,    32767,  32767,  0);
    add_vec("satn0",  1, 32767, 32767, 0,     0,    0,    0,      0, 0, 0,     0,    -32768, -32768, 0);
    add_vec("satn1",  0, 32767, 32767, 0,     0,    0,    0,      0, 0, 0,     0,    -32768, -32768, 0);
    add_vec("fir0",   1, 0,     16384, 16384, 0,    0,    16384,  0, 0, 0,     8192, 1000,   0,      1000);
    add_vec("fir1",   0, 0,     16384, 16384, 0,    0,    16384,  0, 0, 0,     8192, 0,      1000,   0);
    add_vec("fir2",   0, 0,     16384, 16384, 0,    0,    16384,  0, 0, 0,     8192, 0,      1000,   500);
    add_vec("hpfb0",  1, 0,     0,     0,     0,    0,    16384,  0, 0, -8192, 0,    1000,   0,      1000);
    add_vec("hpfb1",  0, 0,     0,     0,     0,    0,    16384,  0, 0, -8192, 0,    0,      0,      -500);
    add_vec("lpyl2a", 1, 16384, 0,     0,     0,    8192, 0,      0, 0, 0,     0,    1000,   1000,   0);
    add_vec("lpyl2b", 0, 16384, 0,     0,     0,    8192, 0,      0, 0, 0,     0,    0,      0,      0);
    add_vec("lpyl2c", 0, 16384, 0,     0,     0,    8192, 0,      0, 0, 0,     0,    0,      500,    0);
    add_vec("floorn", 1, 1,     0,     0,     0,    0,    0,      0, 0, 0,     0,    -1,     -1,     0);
    add_vec("floorp", 1, 1,     0,     0,     0,    0,    0,      0, 0, 0,     0,    1,      0,      0);

    // Reset held with random inputs.
    for (int c = 0; c < 2; c++) begin
      sample_strobe = 1'($urandom);
      filter_rst    = 1'($urandom);
      sample_in     = 16'($urandom);
      step();
      check("rst_busy", busy, 0);
      check("rst_y_valid", y_valid, 0);
      check("rst_y_low", y_low, 0);
      check("rst_y_high", y_high, 0);
      check("rst_mac_en_clr", {mac_en, mac_clr}, 0);
      check("rst_coef_addr", coef_addr, 0);
      check("rst_mac_b", mac_b, 0);
      check("rst_overrun", overrun, 0);
    end
    rst = 1'b1; sample_strobe = 1'b0; filter_rst = 1'b0; sample_in = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("idle_no_mac_en", {busy, mac_en}, 0);
    end

    foreach (vecs[i]) begin
      for (int r = 0; r < 10; r++) rom[r] = vecs[i].rom[r];
      if (vecs[i].frst) pulse_frst();
      run_seq(vecs[i].x, 0, -1, -1);
      check({vecs[i].name, ".y_low"}, y_low, vecs[i].yl);
      check({vecs[i].name, ".y_high"}, y_high, vecs[i].yh);
      check({vecs[i].name, ".yv_cnt"}, yv_cnt, 1);
      check({vecs[i].name, ".yv_cycle"}, yv_first, 14);
      check({vecs[i].name, ".en_cnt"}, en_cnt, 10);
      check({vecs[i].name, ".clr_cnt"}, clr_cnt, 2);
      check({vecs[i].name, ".operands"}, ops_ok, 1);
      check({vecs[i].name, ".overrun"}, ov_cnt, 0);
    end

    // Overrun: second strobe at cycle 5 is dropped.
    rom = '{16384, 0, 0, 0, 0, -16384, 0, 0, 0, 0};
    pulse_frst();
    run_seq(1000, 3000, 5, -1);
    check("ovr.count", ov_cnt, 1);
    check("ovr.cycle", ov_first, 5);
    check("ovr.yv_cnt", yv_cnt, 1);
    check("ovr.yv_cycle", yv_first, 14);
    check("ovr.y_low", y_low, 1000);
    check("ovr.y_high", y_high, -1000);
    check("ovr.en_cnt", en_cnt, 10);

    // filter_rst at WB0 with a simultaneous strobe aborts the sequence.
    rom = '{16384, 0, 0, 8192, 0, 16384, 0, 0, 8192, 0};
    pulse_frst();
    run_seq(1000, 0, -1, -1);
    check("frst.pre_y_low", y_low, 1000);
    check("frst.pre_y_high", y_high, 1000);
    run_seq(0, 0, 7, 7);
    check("frst.busy_after", busy_fr, 0);
    check("frst.y_low_after", yl_fr, 0);
    check("frst.y_high_after", yh_fr, 0);
    check("frst.yv_cnt", yv_cnt, 0);
    check("frst.en_cnt", en_cnt, 5);
    check("frst.idle_end", busy, 0);
    run_seq(200, 0, -1, -1);
    check("frst.post_y_low", y_low, 200);
    check("frst.post_y_high", y_high, 200);
    check("frst.post_yv_cycle", yv_first, 14);

    // Internal divider instance has been running since reset release.
    check("div.first_valid_edge", yv2_first, 33);
    check("div.period", yv2_second - yv2_first, 20);
    check("div.no_overrun", ov2_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
